pe_result_collector: RTL

Gathers the two 64-bit double-precision partial results from each of the 8 processing elements into one 1024-bit block and hands that block to the adder tree. It drives the adder tree's `tempc`/`pedone` inputs and consumes its `tempc_ack`/`done` outputs. A ping-pong bank pair lets the PEs fill the next block while the adder tree is still reducing the current one.

---
 rtl/pe_result_collector_pkg.sv | 14 +
 rtl/pe_result_collector_if.sv | 24 ++
 rtl/pe_result_collector_slot_capture.sv | 38 +++
 rtl/pe_result_collector.sv | 101 ++++++++++
 4 files changed

// File: rtl/pe_result_collector_pkg.sv
// Shared constants and read-FSM state type for the PE result collector.
package mia_pkg;
    localparam int NUM_PE_C = 8;
    localparam int DW_C     = 64;
    localparam int BLK_W_C  = 2 * NUM_PE_C * DW_C;

    localparam logic [NUM_PE_C-1:0] pedone_full_c = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_DONE
    } rd_state_t;
endpackage

// File: rtl/pe_result_collector_if.sv
// PE-side and adder-tree-side signals of the result collector.
interface pe_result_collector_if;
    import mia_pkg::*;

    logic [NUM_PE_C*2*DW_C-1:0] pe_z;
    logic [NUM_PE_C-1:0]        pe_stb;
    logic [NUM_PE_C-1:0]        pe_ack;
    logic [BLK_W_C-1:0]         tempc;
    logic [NUM_PE_C-1:0]        pedone;
    logic                       tempc_ack;
    logic                       done;
    logic [NUM_PE_C-1:0]        fill_mask;
    logic [15:0]                blk_cnt;

    modport master (
        input  pe_z, pe_stb, tempc_ack, done,
        output pe_ack, tempc, pedone, fill_mask, blk_cnt
    );

    modport slave (
        output pe_z, pe_stb, tempc_ack, done,
        input  pe_ack, tempc, pedone, fill_mask, blk_cnt
    );
endinterface

// File: rtl/pe_result_collector_slot_capture.sv
// Per-PE capture control: occupancy bit, registered ack and write enable into the fill bank.
module pe_slot_capture (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic clr,
    output logic mask,
    output logic ack,
    output logic we
);
    logic mask_reg;
    logic mask_next;
    logic ack_reg;

    always_comb begin
        we        = stb & ~mask_reg;
        mask_next = mask_reg;
        // clr only fires when every PE is captured, so it never races a write
        if (clr) begin
            mask_next = 1'b0;
        end else if (we) begin
            mask_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_reg <= 1'b0;
            ack_reg  <= 1'b0;
        end else begin
            mask_reg <= mask_next;
            ack_reg  <= we;
        end
    end

    assign mask = mask_reg;
    assign ack  = ack_reg;
endmodule

// File: rtl/pe_result_collector.sv
// Ping-pong collector: PEs fill one bank while the adder tree reads the other.
module pe_result_collector
    import mia_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    pe_result_collector_if.master bus
);
    localparam int SLOT_W = 2 * DW_C;

    logic [NUM_PE_C-1:0]             we;
    logic [NUM_PE_C-1:0]             mask;
    logic [NUM_PE_C-1:0]             ack;
    logic [NUM_PE_C-1:0][SLOT_W-1:0] bank_reg [2];
    logic                            wsel_reg;
    rd_state_t                       state_reg;
    rd_state_t                       state_next;
    logic [1:0]                      hold_reg;
    logic [1:0]                      hold_next;
    logic [15:0]                     blk_cnt_reg;
    logic                            swap;
    logic                            handoff;

    generate
        for (genvar gi = 0; gi < NUM_PE_C; gi++) begin : g_cap
            pe_slot_capture u_cap (
                .clk  (clk),
                .rst  (rst),
                .stb  (bus.pe_stb[gi]),
                .clr  (swap),
                .mask (mask[gi]),
                .ack  (ack[gi]),
                .we   (we[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        swap       = 1'b0;
        handoff    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mask == pedone_full_c) begin
                    swap       = 1'b1;
                    hold_next  = 2'd0;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (hold_reg != 2'd2) begin
                    hold_next = hold_reg + 2'd1;
                end
                // hold guarantees two presented cycles even with tempc_ack stuck high
                if (hold_reg != 2'd0 && bus.tempc_ack) begin
                    handoff    = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            hold_reg    <= 2'd0;
            wsel_reg    <= 1'b0;
            blk_cnt_reg <= 16'd0;
            for (int b = 0; b < 2; b++) begin
                bank_reg[b] <= '0;
            end
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            if (swap) begin
                wsel_reg <= ~wsel_reg;
            end
            if (handoff) begin
                blk_cnt_reg <= blk_cnt_reg + 16'd1;
            end
            for (int p = 0; p < NUM_PE_C; p++) begin
                if (we[p]) begin
                    bank_reg[wsel_reg][p] <= bus.pe_z[p*SLOT_W +: SLOT_W];
                end
            end
        end
    end

    assign bus.tempc     = bank_reg[!wsel_reg];
    assign bus.pedone    = (state_reg == PRESENT) ? pedone_full_c : '0;
    assign bus.pe_ack    = ack;
    assign bus.fill_mask = mask;
    assign bus.blk_cnt   = blk_cnt_reg;
endmodule
